alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Sequential, parametrised ALU control for the EX stage. It decodes ALUOp/funct into ALU operation, functional-unit select and shift direction, and registers them. It also sequences multi-cycle operations (mult, and div when enabled) with a cycle counter and a stall/ready handshake to the pipeline. It sits between the main decoder and the ALU/shifter/iterative multiplier, and replaces the purely combinational ALU control.

Parameters:
MUL_CYCLES, 32, cycles the iterative multiplier needs, >=1
DIV_CYCLES, 34, cycles the iterative divider needs, >=1; used only with ALU_DIV_EN
CNT_W, 6, counter width; must hold max(MUL_CYCLES,DIV_CYCLES)-1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
valid_i  in  1  ALUOp_i/funct_i valid this cycle
ALUOp_i  in  3  ALU op class from main decoder
funct_i  in  6  R-type funct field
ready_o  out  1  block accepts a new op (combinational: state!=BUSY)
ALU_operation_o  out  4  registered ALU operation code
FURslt_o  out  2  registered result select: 00 ALU, 01 shifter, 10 mul/div unit
leftRight_o  out  1  registered shift direction: 1 right, 0 left
mc_start_o  out  1  one-cycle pulse that starts the iterative unit
stall_o  out  1  holds the pipeline while a multi-cycle op runs
done_o  out  1  one-cycle pulse: result for the accepted op is valid
illegal_o  out  1  registered: accepted op was undefined

Behaviour:
- Reset (async, any state): state=IDLE, counter=0. All outputs 0, except ready_o=1.
- Decode. Entries are ALUOp/funct -> op, FUR, lr.
  - 000 (lw/sw) and 011 (addi) -> 0010, 00, 0.
  - 001 (beq) and 110 (bne) -> 0110, 00, 0.
  - 100 (blt) -> 0111, 00, 0.
  - 101 (bgez) -> 1000, 00, 0.
  - ALUOp 010 (R-type), by funct:
    - 100011 add -> 0010, 00, 0
    - 010011 sub -> 0110, 00, 0
    - 010100 slt -> 0111, 00, 0
    - 010000 nor -> 1100, 00, 0
    - 011111 and -> 0000, 00, 0
    - 101111 or -> 0001, 00, 0
    - 010010 sll -> 0000, 01, 0
    - 100010 srl -> 0001, 01, 1
    - 011000 sllv -> 1001, 01, 0
    - 101000 srlv -> 1010, 01, 1
    - 011001 mult -> 1011, 10, 0 (multi-cycle)
  - Anything else -> 0000, 00, 0 with illegal_o=1. No stall. done_o still pulses.
- Accept: valid_i&&ready_o at a rising edge. Decoded outputs and illegal_o update on that edge and hold until the next accept. valid_i while BUSY is ignored; upstream must hold the op.
- FSM states are IDLE, BUSY and DONE. Transitions:
  - IDLE/DONE, accept of a single-cycle op -> IDLE, done_o=1 next cycle (latency 1).
  - IDLE/DONE, accept of a multi-cycle op -> BUSY. counter=CYCLES-1, mc_start_o=1 for the first BUSY cycle only.
  - BUSY, counter!=0 -> BUSY, counter decrements.
  - BUSY, counter==0 -> DONE.
  - DONE, no accept -> IDLE.
- Timing for a multi-cycle op accepted at edge N:
  - stall_o=1 for exactly CYCLES cycles.
  - done_o=1 in the cycle after the last BUSY cycle.
  - done_o=0 during BUSY.
- Back-to-back: DONE has ready_o=1, so a new op may be accepted in the same cycle done_o is high.
- CYCLES=1: BUSY lasts one cycle, with mc_start_o and stall_o both high in it.
- Reset while BUSY aborts the op with no done_o. The iterative unit is reset by the same rst_i.

Optional Feature:
Macro ALU_DIV_EN.
- Defined: funct 011010 (div) decodes to 1101, 10, 0 as a multi-cycle op with CYCLES=DIV_CYCLES. It uses the same FSM and handshake as mult.
- Not defined: funct 011010 is illegal and the DIV_CYCLES logic is not built.

Test Plan:
- Reset: assert rst_i mid-cycle -> outputs clear immediately; ready_o=1 and all others 0.
- R-type add (ALUOp 010, funct 100011) accepted -> next cycle op=0010, FUR=00, lr=0, done_o=1, stall_o=0.
- srlv (010/101000) followed immediately by slt via blt (100) -> successive cycles show 1010/01/1 then 0111/00/0, with done_o high both cycles.
- mult, MUL_CYCLES=4 -> mc_start_o one cycle; stall_o and ready_o=0 for 4 cycles; then done_o=1, FUR=10, op=1011; a valid_i presented during BUSY is not accepted.
- Reset after 2 BUSY cycles of mult -> state IDLE, stall_o=0 immediately, no done_o afterwards.
- funct 011010: with ALU_DIV_EN, DIV_CYCLES=3 -> stall 3 cycles, op=1101. Without it -> illegal_o=1, op=0000, no stall.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Sequential EX-stage ALU control: registered decode plus IDLE/BUSY/DONE sequencing of multi-cycle ops.
// Optional macro ALU_DIV_EN adds the iterative divide op (funct 011010) and the DIV_CYCLES parameter.
module alu_ctrl_seq #(
    parameter int MUL_CYCLES = 32,
`ifdef ALU_DIV_EN
    parameter int DIV_CYCLES = 34,
`endif
    parameter int CNT_W      = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [2:0] ALUOp_i,
    input  logic [5:0] funct_i,
    output logic       ready_o,
    output logic [3:0] ALU_operation_o,
    output logic [1:0] FURslt_o,
    output logic       leftRight_o,
    output logic       mc_start_o,
    output logic       stall_o,
    output logic       done_o,
    output logic       illegal_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       fur_q, fur_d;
    logic             lr_q, lr_d;
    logic             ill_q, ill_d;
    logic             start_q, start_d;
    logic             sc_done_q, sc_done_d;

    logic [3:0]       dec_op;
    logic [1:0]       dec_fur;
    logic             dec_lr, dec_ill, dec_mc;
    logic [CNT_W-1:0] dec_load;
    logic             accept;

    // Pure decode of the incoming op; only consumed on an accept.
    always_comb begin
        dec_op   = 4'b0000;
        dec_fur  = 2'b00;
        dec_lr   = 1'b0;
        dec_ill  = 1'b0;
        dec_mc   = 1'b0;
        dec_load = CNT_W'(MUL_CYCLES - 1);
        case (ALUOp_i)
            3'b000, 3'b011: dec_op = 4'b0010;
            3'b001, 3'b110: dec_op = 4'b0110;
            3'b100:         dec_op = 4'b0111;
            3'b101:         dec_op = 4'b1000;
            3'b010: begin
                case (funct_i)
                    6'b100011: dec_op = 4'b0010;
                    6'b010011: dec_op = 4'b0110;
                    6'b010100: dec_op = 4'b0111;
                    6'b010000: dec_op = 4'b1100;
                    6'b011111: dec_op = 4'b0000;
                    6'b101111: dec_op = 4'b0001;
                    6'b010010: begin dec_op = 4'b0000; dec_fur = 2'b01; end
                    6'b100010: begin dec_op = 4'b0001; dec_fur = 2'b01; dec_lr = 1'b1; end
                    6'b011000: begin dec_op = 4'b1001; dec_fur = 2'b01; end
                    6'b101000: begin dec_op = 4'b1010; dec_fur = 2'b01; dec_lr = 1'b1; end
                    6'b011001: begin dec_op = 4'b1011; dec_fur = 2'b10; dec_mc = 1'b1; end
`ifdef ALU_DIV_EN
                    6'b011010: begin
                        dec_op   = 4'b1101;
                        dec_fur  = 2'b10;
                        dec_mc   = 1'b1;
                        dec_load = CNT_W'(DIV_CYCLES - 1);
                    end
`endif
                    default:   dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign accept = valid_i && (state_q != BUSY);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 4'b0000;
            fur_q     <= 2'b00;
            lr_q      <= 1'b0;
            ill_q     <= 1'b0;
            start_q   <= 1'b0;
            sc_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            fur_q     <= fur_d;
            lr_q      <= lr_d;
            ill_q     <= ill_d;
            start_q   <= start_d;
            sc_done_q <= sc_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        fur_d     = fur_q;
        lr_d      = lr_q;
        ill_d     = ill_q;
        start_d   = 1'b0;
        sc_done_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d  = dec_op;
                    fur_d = dec_fur;
                    lr_d  = dec_lr;
                    ill_d = dec_ill;
                    if (dec_mc) begin
                        state_d = BUSY;
                        cnt_d   = dec_load;
                        start_d = 1'b1;
                    end else begin
                        sc_done_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Counter reaches zero in the last busy cycle, so BUSY lasts CYCLES cycles.
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o         = (state_q != BUSY);
        stall_o         = (state_q == BUSY);
        mc_start_o      = (state_q == BUSY) && start_q;
        done_o          = (state_q == DONE) || sc_done_q;
        ALU_operation_o = op_q;
        FURslt_o        = fur_q;
        leftRight_o     = lr_q;
        illegal_o       = ill_q;
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized self-checking bench for alu_ctrl_seq against a table-driven decode and cycle-count model.
module tb_alu_ctrl_seq;

    localparam int MULC = 4;
    localparam int DIVC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic [2:0] ALUOp_i = 3'b000;
    logic [5:0] funct_i = 6'b000000;
    logic       ready_o, leftRight_o, mc_start_o, stall_o, done_o, illegal_o;
    logic [3:0] ALU_operation_o;
    logic [1:0] FURslt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(
        .MUL_CYCLES(MULC),
`ifdef ALU_DIV_EN
        .DIV_CYCLES(DIVC),
`endif
        .CNT_W(6)
    ) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ALUOp_i(ALUOp_i), .funct_i(funct_i),
        .ready_o(ready_o), .ALU_operation_o(ALU_operation_o), .FURslt_o(FURslt_o),
        .leftRight_o(leftRight_o), .mc_start_o(mc_start_o), .stall_o(stall_o),
        .done_o(done_o), .illegal_o(illegal_o)
    );

    // Reference: R-type table {funct, op, FUR, lr, multi-cycle}; other ALUOps via a small array.
    typedef struct packed {logic [5:0] f; logic [3:0] op; logic [1:0] fur; logic lr; logic mc;} rent_t;
    rent_t      rtab[$];
    logic [3:0] itab [8];
    logic [7:0] exp_vec = 8'h00;   // {op, fur, lr, illegal} currently expected on the registered outputs

    function automatic void ref_decode(input logic [2:0] a, input logic [5:0] f,
                                       output logic [7:0] v, output int cyc);
        v   = {4'b0000, 2'b00, 1'b0, 1'b1};
        cyc = 0;
        if (a == 3'b010) begin
            foreach (rtab[i])
                if (rtab[i].f == f) begin
                    v   = {rtab[i].op, rtab[i].fur, rtab[i].lr, 1'b0};
                    cyc = !rtab[i].mc ? 0 : (f == 6'b011010) ? DIVC : MULC;
                end
        end else if (a != 3'b111) begin
            v = {itab[a], 2'b00, 1'b0, 1'b0};
        end
    endfunction

    // Present an op at a negedge; returns at the negedge where done_o is expected high.
    task automatic issue(input logic [2:0] a, input logic [5:0] f, input string nm);
        logic [7:0] ev;
        int ecyc, nstall;
        ref_decode(a, f, ev, ecyc);
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_err++; $display("FAIL %s ready_before got %b exp 1", nm, ready_o);
        end
        valid_i = 1'b1; ALUOp_i = a; funct_i = f;
        @(negedge clk);
        valid_i = 1'b0;
        nstall = 0;
        for (int k = 0; k < ecyc + 4 && stall_o; k++) begin
            n_cmp++;
            if ({ready_o, done_o, mc_start_o} !== {1'b0, 1'b0, 1'(k == 0)}) begin
                n_err++;
                $display("FAIL %s busy_cycle%0d ready/done/start got %b%b%b exp 00%0d",
                         nm, k, ready_o, done_o, mc_start_o, (k == 0));
            end
            nstall++;
            // An add offered while busy must be ignored.
            valid_i = 1'b1; ALUOp_i = 3'b010; funct_i = 6'b100011;
            @(negedge clk);
            valid_i = 1'b0;
        end
        n_cmp++;
        if (nstall !== ecyc) begin
            n_err++; $display("FAIL %s stall_cycles got %0d exp %0d", nm, nstall, ecyc);
        end
        n_cmp++;
        if ({done_o, stall_o, mc_start_o, ready_o} !== 4'b1001) begin
            n_err++;
            $display("FAIL %s done_cycle done/stall/start/ready got %b%b%b%b exp 1001",
                     nm, done_o, stall_o, mc_start_o, ready_o);
        end
        exp_vec = ev;
        n_cmp++;
        if ({ALU_operation_o, FURslt_o, leftRight_o, illegal_o} !== ev) begin
            n_err++;
            $display("FAIL %s decode op/fur/lr/ill got %b/%b/%b/%b exp %b/%b/%b/%b", nm,
                     ALU_operation_o, FURslt_o, leftRight_o, illegal_o, ev[7:4], ev[3:2], ev[1], ev[0]);
        end
    endtask

    task automatic idle(input string nm);
        valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done_o, stall_o, mc_start_o, ready_o, ALU_operation_o, FURslt_o, leftRight_o, illegal_o}
            !== {4'b0001, exp_vec}) begin
            n_err++;
            $display("FAIL %s idle done/stall/start/ready/op/fur/lr/ill got %b%b%b%b %h exp 0001 %h",
                     nm, done_o, stall_o, mc_start_o, ready_o,
                     {ALU_operation_o, FURslt_o, leftRight_o, illegal_o}, exp_vec);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ready_o, ALU_operation_o, FURslt_o, leftRight_o, mc_start_o, stall_o, done_o, illegal_o}
            !== {1'b1, 11'd0}) begin
            n_err++; $display("FAIL reset_state got ready=%b op=%b done=%b stall=%b exp ready=1 rest 0",
                              ready_o, ALU_operation_o, done_o, stall_o);
        end
        // Mid-cycle assertion after a nonzero op clears outputs without waiting for a clock edge.
        issue(3'b010, 6'b101000, "pre_reset_srlv");
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ready_o, ALU_operation_o, FURslt_o, leftRight_o, mc_start_o, stall_o, done_o, illegal_o}
            !== {1'b1, 11'd0}) begin
            n_err++; $display("FAIL reset_async got ready=%b op=%b fur=%b lr=%b done=%b exp 1/0000/00/0/0",
                              ready_o, ALU_operation_o, FURslt_o, leftRight_o, done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_vec = 8'h00;
        idle("post_reset");
    endtask

    task automatic test_add();
        issue(3'b010, 6'b100011, "add");
        idle("add_idle");
    endtask

    task automatic test_back_to_back();
        issue(3'b010, 6'b101000, "b2b_srlv");
        issue(3'b100, 6'b000000, "b2b_blt");
        issue(3'b010, 6'b011001, "b2b_mult");
        issue(3'b010, 6'b010011, "b2b_sub_after_mult");
        idle("b2b_idle");
    endtask

    task automatic test_mult();
        issue(3'b010, 6'b011001, "mult");
        idle("mult_idle");
    endtask

    task automatic test_div_funct();
        issue(3'b010, 6'b011010, "div_funct");
        idle("div_idle");
    endtask

    task automatic test_illegal();
        issue(3'b111, 6'b100011, "illegal_aluop");
        issue(3'b010, 6'b111111, "illegal_funct");
        idle("illegal_idle");
    endtask

    task automatic test_reset_busy();
        logic seen_done;
        valid_i = 1'b1; ALUOp_i = 3'b010; funct_i = 6'b011001;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_err++; $display("FAIL rst_busy pre_stall got %b exp 1", stall_o);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({stall_o, ready_o, done_o, mc_start_o, ALU_operation_o} !== {4'b0100, 4'b0000}) begin
            n_err++; $display("FAIL rst_busy_clear stall/ready/done/start/op got %b%b%b%b/%b exp 0100/0000",
                              stall_o, ready_o, done_o, mc_start_o, ALU_operation_o);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < MULC + 4; k++) begin
            @(negedge clk);
            seen_done = seen_done | done_o | stall_o;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_err++; $display("FAIL rst_busy_no_done got done/stall activity=%b exp 0", seen_done);
        end
        exp_vec = 8'h00;
    endtask

    task automatic test_random();
        logic [2:0] a;
        logic [5:0] f;
        for (int n = 0; n < 60; n++) begin
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) a = 3'b010;
            f = 6'($urandom);
            if ($urandom_range(0, 4) != 0) f = rtab[$urandom_range(0, rtab.size() - 1)].f;
            if ($urandom_range(0, 9) == 0) f = 6'b011010;
            issue(a, f, $sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 0) idle($sformatf("rand_idle%0d", n));
        end
        idle("rand_end");
    endtask

    initial begin
        itab = '{4'b0010, 4'b0110, 4'b0000, 4'b0010, 4'b0111, 4'b1000, 4'b0110, 4'b0000};
        rtab.push_back('{6'b100011, 4'b0010, 2'b00, 1'b0, 1'b0});
        rtab.push_back('{6'b010011, 4'b0110, 2'b00, 1'b0, 1'b0});
        rtab.push_back('{6'b010100, 4'b0111, 2'b00, 1'b0, 1'b0});
        rtab.push_back('{6'b010000, 4'b1100, 2'b00, 1'b0, 1'b0});
        rtab.push_back('{6'b011111, 4'b0000, 2'b00, 1'b0, 1'b0});
        rtab.push_back('{6'b101111, 4'b0001, 2'b00, 1'b0, 1'b0});
        rtab.push_back('{6'b010010, 4'b0000, 2'b01, 1'b0, 1'b0});
        rtab.push_back('{6'b100010, 4'b0001, 2'b01, 1'b1, 1'b0});
        rtab.push_back('{6'b011000, 4'b1001, 2'b01, 1'b0, 1'b0});
        rtab.push_back('{6'b101000, 4'b1010, 2'b01, 1'b1, 1'b0});
        rtab.push_back('{6'b011001, 4'b1011, 2'b10, 1'b0, 1'b1});
`ifdef ALU_DIV_EN
        rtab.push_back('{6'b011010, 4'b1101, 2'b10, 1'b0, 1'b1});
`endif
        test_reset();
        test_add();
        test_back_to_back();
        test_mult();
        test_reset_busy();
        test_div_funct();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
